// File: rtl/axi_lite_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_lite_master                                              |
// | Description : AXI4-Lite initiator. Accepts one command at a time on a      |
// |               valid/ready command port, runs the matching AXI4-Lite write  |
// |               (AW+W, then B) or read (AR, then R) and presents the result  |
// |               on a valid/ready response port. All outputs are registered.  |
// |               Optional response-wait timeout: define AXIM_TIMEOUT_EN.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axi_lite_master #(
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int AXI_ADDRESS_WIDTH = 4,
    parameter int TIMEOUT_CYCLES    = 256
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    // command port
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [AXI_ADDRESS_WIDTH-1:0]    cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]       cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]     cmd_wstrb,
    // response port
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]       rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    // write address channel
    output logic [AXI_ADDRESS_WIDTH-1:0]    M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    // write data channel
    output logic [AXI_DATA_WIDTH-1:0]       M_AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]     M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    // write response channel
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    // read address channel
    output logic [AXI_ADDRESS_WIDTH-1:0]    M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    // read data channel
    input  logic [AXI_DATA_WIDTH-1:0]       M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int c_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_DATA = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    state_t                         r_state,       w_state_nx;
    logic                           r_cmd_ready,   w_cmd_ready_nx;
    logic                           r_awvalid,     w_awvalid_nx;
    logic [AXI_ADDRESS_WIDTH-1:0]   r_awaddr,      w_awaddr_nx;
    logic                           r_wvalid,      w_wvalid_nx;
    logic [AXI_DATA_WIDTH-1:0]      r_wdata,       w_wdata_nx;
    logic [c_STRB_WIDTH-1:0]        r_wstrb,       w_wstrb_nx;
    logic                           r_aw_done,     w_aw_done_nx;
    logic                           r_w_done,      w_w_done_nx;
    logic                           r_bready,      w_bready_nx;
    logic                           r_arvalid,     w_arvalid_nx;
    logic [AXI_ADDRESS_WIDTH-1:0]   r_araddr,      w_araddr_nx;
    logic                           r_rready,      w_rready_nx;
    logic                           r_rsp_valid,   w_rsp_valid_nx;
    logic [AXI_DATA_WIDTH-1:0]      r_rsp_rdata,   w_rsp_rdata_nx;
    logic [1:0]                     r_rsp_resp,    w_rsp_resp_nx;
    logic                           r_rsp_timeout, w_rsp_timeout_nx;
    logic                           w_expired;

`ifdef AXIM_TIMEOUT_EN
    localparam int                      c_TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TIMER_WIDTH-1:0] c_TIMER_LAST = c_TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [c_TIMER_WIDTH-1:0] r_timer;

    // Count cycles spent waiting for B/R; cleared whenever not waiting so each wait starts at zero
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            r_timer <= '0;
        end else if ((r_state == S_WR_RESP) || (r_state == S_RD_DATA)) begin
            r_timer <= r_timer + c_TIMER_WIDTH'(1);
        end else begin
            r_timer <= '0;
        end
    end

    assign w_expired = (r_timer == c_TIMER_LAST);
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign w_expired            = 1'b0;
`endif

    // Next-state and next-output decode; every register holds unless a transition changes it
    always_comb begin
        w_state_nx       = r_state;
        w_cmd_ready_nx   = r_cmd_ready;
        w_awvalid_nx     = r_awvalid;
        w_awaddr_nx      = r_awaddr;
        w_wvalid_nx      = r_wvalid;
        w_wdata_nx       = r_wdata;
        w_wstrb_nx       = r_wstrb;
        w_aw_done_nx     = r_aw_done;
        w_w_done_nx      = r_w_done;
        w_bready_nx      = r_bready;
        w_arvalid_nx     = r_arvalid;
        w_araddr_nx      = r_araddr;
        w_rready_nx      = r_rready;
        w_rsp_valid_nx   = r_rsp_valid;
        w_rsp_rdata_nx   = r_rsp_rdata;
        w_rsp_resp_nx    = r_rsp_resp;
        w_rsp_timeout_nx = r_rsp_timeout;

        case (r_state)
            S_IDLE: begin
                // cmd_ready comes up one cycle after reset release or response handshake
                w_cmd_ready_nx = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nx = 1'b0;
                    if (cmd_write) begin
                        w_awaddr_nx  = cmd_addr;
                        w_wdata_nx   = cmd_wdata;
                        w_wstrb_nx   = cmd_wstrb;
                        w_awvalid_nx = 1'b1;
                        w_wvalid_nx  = 1'b1;
                        w_aw_done_nx = 1'b0;
                        w_w_done_nx  = 1'b0;
                        w_state_nx   = S_WR_REQ;
                    end else begin
                        w_araddr_nx  = cmd_addr;
                        w_arvalid_nx = 1'b1;
                        w_state_nx   = S_RD_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                // AW and W complete independently, in any order
                if (r_awvalid && M_AXI_AWREADY) begin
                    w_awvalid_nx = 1'b0;
                    w_aw_done_nx = 1'b1;
                end
                if (r_wvalid && M_AXI_WREADY) begin
                    w_wvalid_nx = 1'b0;
                    w_w_done_nx = 1'b1;
                end
                if (w_aw_done_nx && w_w_done_nx) begin
                    w_bready_nx = 1'b1;
                    w_state_nx  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                // A real B on the expiry cycle takes priority over the timeout
                if (M_AXI_BVALID) begin
                    w_bready_nx      = 1'b0;
                    w_rsp_resp_nx    = M_AXI_BRESP;
                    w_rsp_rdata_nx   = '0;
                    w_rsp_timeout_nx = 1'b0;
                    w_rsp_valid_nx   = 1'b1;
                    w_state_nx       = S_RSP;
                end else if (w_expired) begin
                    w_bready_nx      = 1'b0;
                    w_rsp_resp_nx    = 2'b10;
                    w_rsp_rdata_nx   = '0;
                    w_rsp_timeout_nx = 1'b1;
                    w_rsp_valid_nx   = 1'b1;
                    w_state_nx       = S_RSP;
                end
            end
            S_RD_REQ: begin
                if (r_arvalid && M_AXI_ARREADY) begin
                    w_arvalid_nx = 1'b0;
                    w_rready_nx  = 1'b1;
                    w_state_nx   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    w_rready_nx      = 1'b0;
                    w_rsp_resp_nx    = M_AXI_RRESP;
                    w_rsp_rdata_nx   = M_AXI_RDATA;
                    w_rsp_timeout_nx = 1'b0;
                    w_rsp_valid_nx   = 1'b1;
                    w_state_nx       = S_RSP;
                end else if (w_expired) begin
                    w_rready_nx      = 1'b0;
                    w_rsp_resp_nx    = 2'b10;
                    w_rsp_rdata_nx   = '0;
                    w_rsp_timeout_nx = 1'b1;
                    w_rsp_valid_nx   = 1'b1;
                    w_state_nx       = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nx = 1'b0;
                    w_cmd_ready_nx = 1'b1;
                    w_state_nx     = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b0;
            r_awvalid     <= 1'b0;
            r_awaddr      <= '0;
            r_wvalid      <= 1'b0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_araddr      <= '0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cmd_ready   <= w_cmd_ready_nx;
            r_awvalid     <= w_awvalid_nx;
            r_awaddr      <= w_awaddr_nx;
            r_wvalid      <= w_wvalid_nx;
            r_wdata       <= w_wdata_nx;
            r_wstrb       <= w_wstrb_nx;
            r_aw_done     <= w_aw_done_nx;
            r_w_done      <= w_w_done_nx;
            r_bready      <= w_bready_nx;
            r_arvalid     <= w_arvalid_nx;
            r_araddr      <= w_araddr_nx;
            r_rready      <= w_rready_nx;
            r_rsp_valid   <= w_rsp_valid_nx;
            r_rsp_rdata   <= w_rsp_rdata_nx;
            r_rsp_resp    <= w_rsp_resp_nx;
            r_rsp_timeout <= w_rsp_timeout_nx;
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_timeout   = r_rsp_timeout;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule
`default_nettype wire
